// File: rtl/fft_bitrev_reorder_pkg.sv
// fft_pkg: shared sizes, sample type, FSM states and bit-reversal helper for the FFT reorder unit
package fft_pkg;
  localparam int N = 3;
  localparam int W = 16;
  localparam int FRAME = 1 << N;
  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cpx_t;
  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;
  function automatic logic [N-1:0] bitrev(input logic [N-1:0] value, input int n);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = value[n-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: bit-reversed input stream and natural-order output stream of the reorder unit
interface fft_bitrev_reorder_if;
  import fft_pkg::*;
  logic                start_ip;
  logic signed [W-1:0] ip_re;
  logic signed [W-1:0] ip_im;
  logic                start_op;
  logic                op_valid;
  logic signed [W-1:0] op_re;
  logic signed [W-1:0] op_im;
  modport master(output start_ip, ip_re, ip_im, input start_op, op_valid, op_re, op_im);
  modport slave(input start_ip, ip_re, ip_im, output start_op, op_valid, op_re, op_im);
endinterface

// File: rtl/fft_bitrev_reorder_pp_ram.sv
// fft_pp_ram: two-bank ping-pong sample store addressed as {bank, addr}; read data is registered by the caller
module fft_pp_ram
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [N:0] waddr,
  input  cpx_t       wdata,
  input  logic [N:0] raddr,
  output cpx_t       rdata
);
  cpx_t mem [2*FRAME];
  // Plain write port, no reset so it maps onto RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: reorders bit-reversed FFT frames into natural bin order using ping-pong banks
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  fft_bitrev_reorder_if.slave bus
);
  w_state_t     w_state, w_next;
  r_state_t     r_state, r_next;
  logic [N-1:0] wr_pos, wr_pos_n, rd_idx, rd_idx_n;
  logic         wr_bank, wr_bank_n, rd_bank, rd_bank_n;
  logic         we, handoff, drain;
  logic [N:0]   waddr, raddr;
  cpx_t         wdata, rdata;
  assign wdata = '{re: bus.ip_re, im: bus.ip_im};
  fft_pp_ram u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );
  // Next-state logic: a start always reopens position 0 of the current bank; the last fill position hands the bank to the reader, which restarts at bin 0 even when finishing the previous drain
  always_comb begin
    handoff   = w_state == W_FILL && !bus.start_ip && wr_pos == '1;
    we        = bus.start_ip || w_state == W_FILL;
    w_next    = bus.start_ip ? W_FILL : handoff ? W_IDLE : w_state;
    wr_pos_n  = bus.start_ip ? N'(1) : wr_pos + 1'b1;
    wr_bank_n = handoff ? ~wr_bank : wr_bank;
    waddr     = {wr_bank, bus.start_ip ? {N{1'b0}} : bitrev(wr_pos, N)};
    drain     = r_state == R_DRAIN;
    r_next    = handoff ? R_DRAIN : (drain && rd_idx == '1) ? R_IDLE : r_state;
    rd_idx_n  = handoff ? '0 : rd_idx + 1'b1;
    rd_bank_n = handoff ? wr_bank : rd_bank;
    raddr     = {rd_bank, rd_idx};
  end
  // State, counter and bank-select registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wr_pos  <= '0;
      rd_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      wr_pos  <= wr_pos_n;
      rd_idx  <= rd_idx_n;
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
    end
  // Output registers double as the RAM read register; data holds while not draining
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.start_op <= 1'b0;
      bus.op_valid <= 1'b0;
      bus.op_re    <= '0;
      bus.op_im    <= '0;
    end else begin
      bus.start_op <= drain && rd_idx == '0;
      bus.op_valid <= drain;
      if (drain) begin
        bus.op_re <= rdata.re;
        bus.op_im <= rdata.im;
      end
    end
endmodule
